// File: rtl/store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : store_unit_if
//  Description : Request, memory-write and status bundle of the store unit.
//                The slave side is the store unit itself; the master side is
//                the pipeline/memory environment driving it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface store_unit_if;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [11:0] imm;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_we;
  logic        d_ack;
  logic        done;
  logic        err;
  logic [1:0]  err_cause;

  modport slave (
    input  start, opcode, funct3, imm, in1, in2, d_ack,
    output busy, d_addr, d_wdata, d_be, d_we, done, err, err_cause
  );

  modport master (
    output start, opcode, funct3, imm, in1, in2, d_ack,
    input  busy, d_addr, d_wdata, d_be, d_we, done, err, err_cause
  );
endinterface
`default_nettype wire

// File: rtl/store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : store_unit
//  Description : Executes SB/SH/SW stores: computes the effective address,
//                checks width and alignment, issues one lane-replicated word
//                write and waits for the acknowledge with a bounded timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  store_unit_if.slave  bus
);

  localparam logic [6:0] c_OP_STORE  = 7'b0100011;

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_WRITE     = 2'd1;
  localparam logic [1:0] c_DONE      = 2'd2;
  localparam logic [1:0] c_ERR       = 2'd3;

  localparam logic [1:0] c_CAUSE_MIS = 2'b01;
  localparam logic [1:0] c_CAUSE_ILL = 2'b10;
  localparam logic [1:0] c_CAUSE_TMO = 2'b11;

  // Last wait count before giving up; d_we is then high for TIMEOUT cycles.
  localparam logic [7:0] c_TMO_LAST  = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q,   cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q,    be_d;

  logic [31:0] w_ea;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic        w_legal;
  logic        w_misal;

  // Effective address wraps modulo 2^32 with the sign-extended offset.
  assign w_ea = bus.in1 + {{20{bus.imm[11]}}, bus.imm};

  // Width decode: lane replication, byte enables, legality and alignment.
  always_comb begin
    w_wdata = bus.in2;
    w_be    = 4'b0000;
    w_legal = 1'b1;
    w_misal = 1'b0;
    case (bus.funct3)
      3'b000: begin
        w_wdata = {4{bus.in2[7:0]}};
        w_be    = 4'b0001 << w_ea[1:0];
      end
      3'b001: begin
        w_wdata = {2{bus.in2[15:0]}};
        w_be    = 4'b0011 << w_ea[1:0];
        w_misal = w_ea[0];
      end
      3'b010: begin
        w_wdata = bus.in2;
        w_be    = 4'b1111;
        w_misal = |w_ea[1:0];
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Next-state logic; bus registers only change when a write is launched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      c_IDLE: begin
        if (bus.start && (bus.opcode == c_OP_STORE)) begin
          if (!w_legal) begin
            state_d = c_ERR;
            cause_d = c_CAUSE_ILL;
          end else if (w_misal) begin
            state_d = c_ERR;
            cause_d = c_CAUSE_MIS;
          end else begin
            state_d = c_WRITE;
            cnt_d   = 8'd0;
            addr_d  = {w_ea[31:2], 2'b00};
            wdata_d = w_wdata;
            be_d    = w_be;
          end
        end
      end
      c_WRITE: begin
        // Acknowledge takes priority over an expiring wait counter.
        if (bus.d_ack) begin
          state_d = c_DONE;
        end else if (cnt_q == c_TMO_LAST) begin
          state_d = c_ERR;
          cause_d = c_CAUSE_TMO;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_IDLE;
      cnt_q   <= 8'd0;
      cause_q <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  // Status outputs decode directly from state so reset clears them at once.
  assign bus.busy      = (state_q != c_IDLE);
  assign bus.d_we      = (state_q == c_WRITE);
  assign bus.done      = (state_q == c_DONE);
  assign bus.err       = (state_q == c_ERR);
  assign bus.err_cause = (state_q == c_ERR) ? cause_q : 2'b00;
  assign bus.d_addr    = addr_q;
  assign bus.d_wdata   = wdata_q;
  assign bus.d_be      = be_q;

endmodule
`default_nettype wire

// File: tb/tb_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_unit
//  Description : Scoreboard testbench for store_unit (TIMEOUT = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_unit;

  localparam logic [6:0] c_ST = 7'b0100011;
  localparam logic [6:0] c_LD = 7'b0000011;

  typedef struct packed {
    logic        is_err;
    logic [1:0]  cause;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  store_unit_if bus ();

  store_unit #(.TIMEOUT(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour of one request.
  function automatic exp_t model(input logic [2:0] f3, input logic [11:0] imm,
                                 input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    logic [31:0] ea;
    e  = '0;
    ea = a + {{20{imm[11]}}, imm};
    e.addr = {ea[31:2], 2'b00};
    case (f3)
      3'b000: begin
        e.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
        case (ea[1:0])
          2'd0: e.be = 4'b0001;
          2'd1: e.be = 4'b0010;
          2'd2: e.be = 4'b0100;
          default: e.be = 4'b1000;
        endcase
      end
      3'b001: begin
        if (ea[0]) begin e.is_err = 1'b1; e.cause = 2'b01; end
        else begin
          e.wdata = {d[15:0], d[15:0]};
          e.be    = ea[1] ? 4'b1100 : 4'b0011;
        end
      end
      3'b010: begin
        if (ea[1:0] != 2'b00) begin e.is_err = 1'b1; e.cause = 2'b01; end
        else begin e.wdata = d; e.be = 4'b1111; end
      end
      default: begin e.is_err = 1'b1; e.cause = 2'b10; end
    endcase
    return e;
  endfunction

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [11:0] imm,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = op; bus.funct3 = f3;
    bus.imm = imm; bus.in1 = a; bus.in2 = d;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Waits (bounded) for either a write request or an error pulse.
  task automatic wait_resp(input int budget, output bit we, output bit er, output int n);
    we = 1'b0; er = 1'b0; n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      n++;
      if (bus.d_we) begin we = 1'b1; break; end
      if (bus.err)  begin er = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 0; bus.opcode = 0; bus.funct3 = 0; bus.imm = 0;
    bus.in1 = 0; bus.in2 = 0; bus.d_ack = 0;
    #2;
    checks++;
    if ({bus.busy, bus.d_we, bus.done, bus.err} !== 4'b0000) begin
      failures++; $display("FAIL reset_status: got %b exp 0000", {bus.busy, bus.d_we, bus.done, bus.err});
    end
    checks++;
    if ({bus.d_addr, bus.d_wdata, bus.d_be, bus.err_cause} !== 70'd0) begin
      failures++; $display("FAIL reset_bus: got %h/%h/%b/%b exp zeros", bus.d_addr, bus.d_wdata, bus.d_be, bus.err_cause);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Launches a write expected to succeed, checks bus values, acks after
  // `waits` extra cycles, and checks the done pulse.
  task automatic test_write(input string name, input logic [2:0] f3, input logic [11:0] imm,
                            input logic [31:0] a, input logic [31:0] d, input exp_t e, input int waits);
    bit   we, er;
    int   n;
    exp_t x;
    sb.push_back(e);
    issue(c_ST, f3, imm, a, d);
    wait_resp(6, we, er, n);
    x = sb.pop_front();
    checks++;
    if (we !== 1'b1 || n != 1) begin
      failures++; $display("FAIL %s_we_latency: got we=%0b n=%0d exp we=1 n=1", name, we, n);
    end
    for (int i = 0; i <= waits; i++) begin
      checks++;
      if ({bus.d_we, bus.d_addr, bus.d_wdata, bus.d_be} !== {1'b1, x.addr, x.wdata, x.be}) begin
        failures++;
        $display("FAIL %s_bus[%0d]: got we=%0b %h %h %b exp we=1 %h %h %b", name, i,
                 bus.d_we, bus.d_addr, bus.d_wdata, bus.d_be, x.addr, x.wdata, x.be);
      end
      if (i < waits) @(negedge clk);
    end
    bus.d_ack = 1'b1;
    @(negedge clk);
    bus.d_ack = 1'b0;
    checks++;
    if ({bus.done, bus.err, bus.d_we, bus.busy} !== 4'b1001) begin
      failures++; $display("FAIL %s_done: got done/err/we/busy=%b exp 1001", name, {bus.done, bus.err, bus.d_we, bus.busy});
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      failures++; $display("FAIL %s_idle: got done/busy=%b exp 00", name, {bus.done, bus.busy});
    end
  endtask

  task automatic test_error(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [1:0] cause);
    bit   we, er;
    int   n;
    exp_t x;
    sb.push_back('{is_err: 1'b1, cause: cause, addr: 32'd0, wdata: 32'd0, be: 4'd0});
    issue(c_ST, f3, 12'h000, a, 32'hCAFE_F00D);
    wait_resp(6, we, er, n);
    x = sb.pop_front();
    checks++;
    if ({er, we, bus.err_cause, bus.done} !== {1'b1, 1'b0, x.cause, 1'b0}) begin
      failures++; $display("FAIL %s: got err=%0b we=%0b cause=%b done=%0b exp err=1 we=0 cause=%b done=0",
                           name, er, we, bus.err_cause, bus.done, x.cause);
    end
    @(negedge clk);
    checks++;
    if ({bus.err, bus.err_cause, bus.busy} !== 4'b0000) begin
      failures++; $display("FAIL %s_clear: got err/cause/busy=%b exp 0000", name, {bus.err, bus.err_cause, bus.busy});
    end
  endtask

  task automatic test_timeout(input bit ack_last);
    bit we, er;
    int n, cyc;
    issue(c_ST, 3'b010, 12'h000, 32'h0000_0100, 32'h1111_2222);
    wait_resp(6, we, er, n);
    cyc = we ? 1 : 0;
    while (bus.d_we && cyc < 10) begin
      if (ack_last && cyc == 4) begin bus.d_ack = 1'b1; end
      @(negedge clk);
      if (bus.d_we) cyc++;
    end
    bus.d_ack = 1'b0;
    checks++;
    if (cyc != 4) begin
      failures++; $display("FAIL timeout_we_cycles(ack=%0b): got %0d exp 4", ack_last, cyc);
    end
    checks++;
    if (ack_last) begin
      if ({bus.done, bus.err} !== 2'b10) begin
        failures++; $display("FAIL ack_on_last: got done/err=%b exp 10", {bus.done, bus.err});
      end
    end else if ({bus.err, bus.err_cause, bus.done} !== 4'b1110) begin
      failures++; $display("FAIL timeout_err: got err/cause/done=%b exp 1110", {bus.err, bus.err_cause, bus.done});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_write();
    bit we, er;
    int n;
    bit pulse;
    issue(c_ST, 3'b010, 12'h000, 32'h0000_0500, 32'h5555_5555);
    wait_resp(6, we, er, n);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.d_we, bus.busy, bus.d_addr} !== 34'd0) begin
      failures++; $display("FAIL reset_in_write: got we=%0b busy=%0b addr=%h exp 0 0 0", bus.d_we, bus.busy, bus.d_addr);
    end
    #1 rst = 1'b0;
    pulse = 1'b0;
    repeat (3) begin
      @(negedge clk);
      pulse |= bus.done | bus.err | bus.d_we;
    end
    checks++;
    if (pulse !== 1'b0) begin
      failures++; $display("FAIL reset_discard: got activity=%0b exp 0", pulse);
    end
    test_write("sw_after_reset", 3'b010, 12'h000, 32'h0000_4000, 32'hDEAD_BEEF,
               '{is_err: 1'b0, cause: 2'b00, addr: 32'h4000, wdata: 32'hDEAD_BEEF, be: 4'b1111}, 0);
  endtask

  task automatic test_ignored();
    bit we, er;
    int n;
    bit act;
    issue(c_LD, 3'b010, 12'h000, 32'h0000_0800, 32'h0);
    act = 1'b0;
    repeat (3) begin
      @(negedge clk);
      act |= bus.busy | bus.d_we | bus.done | bus.err;
    end
    checks++;
    if (act !== 1'b0 || bus.d_addr !== 32'h4000) begin
      failures++; $display("FAIL load_ignored: got act=%0b addr=%h exp 0 00004000", act, bus.d_addr);
    end
    // Start while busy must be dropped, not queued.
    issue(c_ST, 3'b010, 12'h000, 32'h0000_0600, 32'h6666_6666);
    wait_resp(6, we, er, n);
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.in1 = 32'h0000_0703; bus.in2 = 32'h77;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if ({bus.d_addr, bus.d_be} !== {32'h0600, 4'b1111}) begin
      failures++; $display("FAIL start_while_busy: got %h %b exp 00000600 1111", bus.d_addr, bus.d_be);
    end
    bus.d_ack = 1'b1;
    @(negedge clk);
    bus.d_ack = 1'b0;
    act = 1'b0;
    repeat (3) begin
      @(negedge clk);
      act |= bus.busy | bus.d_we;
    end
    checks++;
    if (act !== 1'b0) begin
      failures++; $display("FAIL start_not_queued: got activity=%0b exp 0", act);
    end
  endtask

  task automatic test_random();
    bit          we, er;
    int          n;
    exp_t        e, x;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] a, d;
    for (int k = 0; k < 10; k++) begin
      f3  = 3'($urandom_range(0, 3));
      imm = 12'($urandom);
      a   = $urandom;
      d   = $urandom;
      e   = model(f3, imm, a, d);
      sb.push_back(e);
      issue(c_ST, f3, imm, a, d);
      wait_resp(6, we, er, n);
      x = sb.pop_front();
      checks++;
      if (x.is_err) begin
        if ({er, bus.err_cause} !== {1'b1, x.cause}) begin
          failures++; $display("FAIL rand%0d_err: got err=%0b cause=%b exp 1 %b", k, er, bus.err_cause, x.cause);
        end
      end else if ({we, bus.d_addr, bus.d_wdata, bus.d_be} !== {1'b1, x.addr, x.wdata, x.be}) begin
        failures++; $display("FAIL rand%0d_bus: got we=%0b %h %h %b exp 1 %h %h %b", k, we,
                             bus.d_addr, bus.d_wdata, bus.d_be, x.addr, x.wdata, x.be);
      end
      if (!x.is_err) begin
        bus.d_ack = 1'b1;
        @(negedge clk);
        bus.d_ack = 1'b0;
        checks++;
        if ({bus.done, bus.err} !== 2'b10) begin
          failures++; $display("FAIL rand%0d_done: got done/err=%b exp 10", k, {bus.done, bus.err});
        end
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_write("sb", 3'b000, 12'h003, 32'h0000_1000, 32'h0000_00A5,
               '{is_err: 1'b0, cause: 2'b00, addr: 32'h1000, wdata: 32'hA5A5_A5A5, be: 4'b1000}, 0);
    test_write("sh", 3'b001, 12'hFFE, 32'h0000_2000, 32'h0000_1234,
               '{is_err: 1'b0, cause: 2'b00, addr: 32'h1FFC, wdata: 32'h1234_1234, be: 4'b1100}, 2);
    test_error("sw_misaligned", 3'b010, 32'h0000_3001, 2'b01);
    test_error("illegal_funct3", 3'b011, 32'h0000_3001, 2'b10);
    test_error("sh_odd", 3'b001, 32'h0000_3003, 2'b01);
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_in_write();
    test_ignored();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
